// File: rtl/pci_rr_arbiter.sv
// Central PCI bus arbiter: round-robin GNT# with hidden arbitration and a grant-to-FRAME# timeout.
// Build option: define PCI_ARB_PARK_EN to park the bus on PARK_ID when nobody requests.
module pci_rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int GNT_TIMEOUT = 16,
    parameter int PARK_ID     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req_n,
    input  logic                           frame_n,
    input  logic                           irdy_n,
    output logic [NUM_MASTERS-1:0]         gnt_n,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           timeout_pulse,
    output logic [1:0]                     state_dbg
);
    // Handshake: a master asks by holding REQ# low; GNT# low is permission to start a
    // transaction once the bus is idle, and it may be withdrawn any time before FRAME# falls.
    localparam int OW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(GNT_TIMEOUT);
    localparam logic [NUM_MASTERS-1:0] ALL_OFF  = '1;
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] PARK_GNT = ~(ONE << PARK_ID);
    localparam logic [OW-1:0]          PARK_OWN = OW'(PARK_ID);
`ifdef PCI_ARB_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   timeout_pulse_q, timeout_pulse_d;

    logic [NUM_MASTERS-1:0] req, own_mask;
    logic                   bus_idle, any_req, any_other, owner_req, parked, rr_found;
    logic [OW-1:0]          rr_winner, rr_idx;

    function automatic logic [NUM_MASTERS-1:0] gnt_for(input logic [OW-1:0] id);
        return ~(ONE << id);
    endfunction

    assign req       = ~req_n;
    assign bus_idle  = frame_n & irdy_n;
    assign own_mask  = ONE << owner_q;
    assign any_req   = |req;
    assign any_other = |(req & ~own_mask);
    assign owner_req = |(req & own_mask);
    assign parked    = PARK_EN && (state_q == IDLE) && (gnt_q == PARK_GNT);

    // Search starts just after the current owner, so the owner has lowest priority.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = owner_q;
        rr_idx    = owner_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rr_idx = OW'((int'(owner_q) + k) % NUM_MASTERS);
            if (!rr_found && req[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        owner_d         = owner_q;
        timer_d         = timer_q;
        timeout_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    // Handing the bus from the parked master to someone else needs a turnaround.
                    if (parked && (rr_winner != owner_q)) begin
                        gnt_d   = ALL_OFF;
                        state_d = GAP;
                    end else begin
                        gnt_d   = gnt_for(rr_winner);
                        owner_d = rr_winner;
                        timer_d = '0;
                        state_d = GRANT;
                    end
                end else if (parked && !frame_n) begin
                    state_d = BUSY;
                end else if (PARK_EN) begin
                    gnt_d   = PARK_GNT;
                    owner_d = PARK_OWN;
                end
            end
            GRANT: begin
                if (!frame_n) begin
                    state_d = BUSY;
                end else if (!owner_req) begin
                    gnt_d   = ALL_OFF;
                    state_d = any_other ? GAP : IDLE;
                end else if (bus_idle) begin
                    if (timer_q == TW'(GNT_TIMEOUT - 1)) begin
                        gnt_d           = ALL_OFF;
                        timeout_pulse_d = 1'b1;
                        state_d         = GAP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    if (any_other || owner_req) begin
                        gnt_d   = gnt_for(rr_winner);
                        owner_d = rr_winner;
                        timer_d = '0;
                        state_d = GRANT;
                    end else begin
                        gnt_d   = ALL_OFF;
                        state_d = IDLE;
                    end
                end else if (any_other) begin
                    gnt_d = ALL_OFF;
                end
            end
            GAP: begin
                if (any_req) begin
                    gnt_d   = gnt_for(rr_winner);
                    owner_d = rr_winner;
                    timer_d = '0;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = ALL_OFF;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            gnt_q           <= ALL_OFF;
            owner_q         <= '0;
            timer_q         <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            owner_q         <= owner_d;
            timer_q         <= timer_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign gnt_n         = gnt_q;
    assign owner         = owner_q;
    assign timeout_pulse = timeout_pulse_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Self-checking bench for pci_rr_arbiter (3 masters, GNT_TIMEOUT=16, PARK_ID=0).
module tb_pci_rr_arbiter;
    localparam int N  = 3;
    localparam int OW = 2;
    localparam int W  = N + OW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_n = '1;
    logic          frame_n = 1'b1;
    logic          irdy_n = 1'b1;
    logic [N-1:0]  gnt_n;
    logic [OW-1:0] owner;
    logic          timeout_pulse;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    pci_rr_arbiter #(
        .NUM_MASTERS(N),
        .GNT_TIMEOUT(16),
        .PARK_ID    (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_n        (req_n),
        .frame_n      (frame_n),
        .irdy_n       (irdy_n),
        .gnt_n        (gnt_n),
        .owner        (owner),
        .timeout_pulse(timeout_pulse),
        .state_dbg    (state_dbg)
    );

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    typedef struct {
        logic [N-1:0]  req_n;
        logic          frame_n;
        logic          irdy_n;
        logic [N-1:0]  gnt_n;
        logic [OW-1:0] owner;
        logic          pulse;
        string         tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic [N-1:0] r, input logic f, input logic i,
                       input logic [N-1:0] g, input logic [OW-1:0] o, input logic p);
        vec_t v;
        v.req_n = r; v.frame_n = f; v.irdy_n = i;
        v.gnt_n = g; v.owner = o; v.pulse = p; v.tag = tag;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
    task automatic step(input logic rs, input logic [N-1:0] r, input logic f, input logic i,
                        input logic [N-1:0] g, input logic [OW-1:0] o, input logic p,
                        input string tag);
        logic [W-1:0] exp_v, act_v;
        string        t;
        rst = rs; req_n = r; frame_n = f; irdy_n = i;
        exp_q.push_back({g, o, p});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        act_v = {gnt_n, owner, timeout_pulse};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got gnt_n=%b owner=%0d pulse=%b, want gnt_n=%b owner=%0d pulse=%b",
                     t, act_v[W-1 -: N], act_v[OW:1], act_v[0], exp_v[W-1 -: N], exp_v[OW:1], exp_v[0]);
        end
        n_cmp++;
        if ($countones(~gnt_n) > 1) begin
            n_err++;
            $display("FAIL %s_onehot: got gnt_n=%b, want at most one low bit", t, gnt_n);
        end
    endtask

    initial begin
        step(1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, "reset");
        n_cmp++;
        if (state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got state=%0d, want 0", state_dbg);
        end

`ifdef PCI_ARB_PARK_EN
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, "park");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, "park_hold");
        step(1'b0, 3'b011, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, "park_gap");
        step(1'b0, 3'b011, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0, "park_handoff");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, "park_drop");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, "repark");
        step(1'b0, 3'b110, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, "park_self");
        step(1'b0, 3'b110, 1'b0, 1'b1, 3'b110, 2'd0, 1'b0, "park_frame");
        step(1'b0, 3'b111, 1'b1, 1'b0, 3'b110, 2'd0, 1'b0, "park_last");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, "park_done");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, "repark2");
        step(1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, "park_rst");
`else
        // Grant to master 0, hidden arbitration toward master 2, then idle.
        add("first_grant",   3'b110, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0);
        add("addr_phase",    3'b010, 1'b0, 1'b1, 3'b110, 2'd0, 1'b0);
        add("hidden_arb1",   3'b010, 1'b0, 1'b0, 3'b111, 2'd0, 1'b0);
        add("hidden_arb2",   3'b010, 1'b0, 1'b0, 3'b111, 2'd0, 1'b0);
        add("last_data",     3'b010, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0);
        add("idle_handover", 3'b010, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0);
        add("owner_drop",    3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0);
        add("idle_stay",     3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0);
        // All masters request; each runs an address phase and one data phase.
        add("rr_g0",  3'b000, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0);
        add("rr_a0",  3'b000, 1'b0, 1'b1, 3'b110, 2'd0, 1'b0);
        add("rr_d0",  3'b000, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0);
        add("rr_g1",  3'b000, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0);
        add("rr_a1",  3'b000, 1'b0, 1'b1, 3'b101, 2'd1, 1'b0);
        add("rr_d1",  3'b000, 1'b1, 1'b0, 3'b111, 2'd1, 1'b0);
        add("rr_g2",  3'b000, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0);
        add("rr_a2",  3'b000, 1'b0, 1'b1, 3'b011, 2'd2, 1'b0);
        add("rr_d2",  3'b000, 1'b1, 1'b0, 3'b111, 2'd2, 1'b0);
        add("rr_g0b", 3'b000, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0);
        add("rr_rel", 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0);
        for (int i = 0; i < vecs.size(); i++)
            step(1'b0, vecs[i].req_n, vecs[i].frame_n, vecs[i].irdy_n,
                 vecs[i].gnt_n, vecs[i].owner, vecs[i].pulse, vecs[i].tag);

        // Unused grant to master 1: 16 cycles low, timeout pulse, GAP, re-grant.
        step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "to_grant");
        for (int i = 0; i < 15; i++)
            step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "to_hold");
        step(1'b0, 3'b101, 1'b1, 1'b1, 3'b111, 2'd1, 1'b1, "to_revoke");
        step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "to_regrant");
        // A busy bus (IRDY# low) freezes the timer.
        for (int i = 0; i < 3; i++)
            step(1'b0, 3'b101, 1'b1, 1'b0, 3'b101, 2'd1, 1'b0, "to_irdy_hold");
        for (int i = 0; i < 15; i++)
            step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "to_hold2");
        step(1'b0, 3'b101, 1'b1, 1'b1, 3'b111, 2'd1, 1'b1, "to_revoke2");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd1, 1'b0, "gap_to_idle");

        // FRAME# falls on the very edge the timer would expire: no timeout.
        step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "fw_grant");
        for (int i = 0; i < 15; i++)
            step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "fw_hold");
        step(1'b0, 3'b101, 1'b0, 1'b1, 3'b101, 2'd1, 1'b0, "fw_frame_wins");
        step(1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 2'd1, 1'b0, "fw_busy");
        step(1'b0, 3'b101, 1'b1, 1'b0, 3'b101, 2'd1, 1'b0, "fw_last");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd1, 1'b0, "fw_done");

        // Reset in the middle of master 1's transaction.
        step(1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b0, "rst_grant");
        step(1'b0, 3'b101, 1'b0, 1'b1, 3'b101, 2'd1, 1'b0, "rst_busy");
        step(1'b1, 3'b101, 1'b0, 1'b0, 3'b111, 2'd0, 1'b0, "rst_mid");
        step(1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, "rst_after");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
